seg_scan_controller: RTL and testbench

Time-multiplexes one shared hex-to-seven-segment decoder across the four digits of the Basys3 display. Sequences the digit code presented to the decoder, drives the active-low anodes and decimal point, and inserts a blanking gap at each digit change to suppress ghosting. Holds a shadow/active value pair so a new 16-bit value is applied atomically at a frame boundary, with a load/acknowledge handshake.

---
 rtl/seg_scan_controller.sv | 133 +++++++++++++
 tb/tb_seg_scan_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Four-digit multiplexed seven-segment scanner for the Basys3 display.
// Sequences one shared hex decoder across the digits, with a blanking gap per slot and atomic frame-boundary value updates.
module seg_scan_controller #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   input  logic        lzb,
   output logic        load_ack,
   output logic [3:0]  hex_digit,
   output logic [3:0]  an,
   output logic        dp,
   output logic        frame_tick
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    digit_q, digit_d;
   logic [15:0]   activeVal_q, activeVal_d;
   logic [3:0]    activeDp_q, activeDp_d;
   logic [15:0]   shadowVal_q, shadowVal_d;
   logic [3:0]    shadowDp_q, shadowDp_d;
   logic          pending_q, pending_d;
   logic          blank_q, blank_d;
   logic [3:0]    hex_q, hex_d;
   logic [3:0]    an_q, an_d;
   logic          dp_q, dp_d;
   logic          ack_q, ack_d;
   logic          tick_q, tick_d;

   logic slotEnd, wrap, commit, upperZero, lit;

   // Outputs are registered from the next-state values so each reflects the slot the counter is entering.
   always_comb begin
      slotEnd     = (cnt_q == SLOT_LAST);
      wrap        = slotEnd && (digit_q == 2'd3);
      commit      = wrap && pending_q;

      cnt_d       = slotEnd ? '0 : cnt_q + 1'b1;
      digit_d     = slotEnd ? digit_q + 2'd1 : digit_q;

      state_d     = state_q;
      case (state_q)
         BLANK:   if (cnt_q == BLANK_LAST) state_d = SHOW;
         SHOW:    if (slotEnd) state_d = BLANK;
         default: state_d = BLANK;
      endcase

      activeVal_d = commit ? shadowVal_q : activeVal_q;
      activeDp_d  = commit ? shadowDp_q  : activeDp_q;

      // A load on the commit edge wins over the clear, so it waits for the next frame.
      shadowVal_d = shadowVal_q;
      shadowDp_d  = shadowDp_q;
      pending_d   = commit ? 1'b0 : pending_q;
      if (load) begin
         shadowVal_d = value_in;
         shadowDp_d  = dp_in;
         pending_d   = 1'b1;
      end

      upperZero   = 1'b0;
      case (digit_d)
         2'd1:    upperZero = (activeVal_d[15:4]  == 12'h000);
         2'd2:    upperZero = (activeVal_d[15:8]  == 8'h00);
         2'd3:    upperZero = (activeVal_d[15:12] == 4'h0);
         default: upperZero = 1'b0;
      endcase
      blank_d     = slotEnd ? (lzb && upperZero) : blank_q;

      lit         = (state_d == SHOW) && !blank_d;
      hex_d       = activeVal_d[{digit_d, 2'b00} +: 4];
      an_d        = lit ? ~(4'b0001 << digit_d) : 4'b1111;
      dp_d        = lit ? ~activeDp_d[digit_d] : 1'b1;
      ack_d       = commit;
      tick_d      = wrap;
   end

   // Single state register for the scan FSM, handshake and output stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= BLANK;
         cnt_q       <= '0;
         digit_q     <= 2'd0;
         activeVal_q <= 16'h0000;
         activeDp_q  <= 4'h0;
         shadowVal_q <= 16'h0000;
         shadowDp_q  <= 4'h0;
         pending_q   <= 1'b0;
         blank_q     <= 1'b0;
         hex_q       <= 4'h0;
         an_q        <= 4'b1111;
         dp_q        <= 1'b1;
         ack_q       <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         digit_q     <= digit_d;
         activeVal_q <= activeVal_d;
         activeDp_q  <= activeDp_d;
         shadowVal_q <= shadowVal_d;
         shadowDp_q  <= shadowDp_d;
         pending_q   <= pending_d;
         blank_q     <= blank_d;
         hex_q       <= hex_d;
         an_q        <= an_d;
         dp_q        <= dp_d;
         ack_q       <= ack_d;
         tick_q      <= tick_d;
      end
   end

   assign load_ack   = ack_q;
   assign hex_digit  = hex_q;
   assign an         = an_q;
   assign dp         = dp_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller at REFRESH_DIV=8, BLANK_CYCLES=2.
// Expected outputs come from a slot/offset model of the display timing.
module tb_seg_scan_controller;

   localparam int RD = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] valueIn;
   logic [3:0]  dpIn;
   logic        load;
   logic        lzb;
   logic        loadAck;
   logic [3:0]  hexDigit;
   logic [3:0]  an;
   logic        dp;
   logic        frameTick;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] hex;
      logic       dp;
      logic       ack;
      logic       tick;
   } exp_t;

   exp_t sbQueue[$];
   int   checks   = 0;
   int   failures = 0;

   seg_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk       (clk),
      .reset     (reset),
      .value_in  (valueIn),
      .dp_in     (dpIn),
      .load      (load),
      .lzb       (lzb),
      .load_ack  (loadAck),
      .hex_digit (hexDigit),
      .an        (an),
      .dp        (dp),
      .frame_tick(frameTick)
   );

   always #5 clk = ~clk;

   // Expected outputs seen just before edge k, given the value displayed in that frame.
   function automatic exp_t modelAt(int k, logic [15:0] v, logic [3:0] dpv, bit lz, bit ack);
      exp_t e;
      int   slot;
      int   off;
      bit   blanked;
      bit   litNow;
      slot    = (k / RD) % 4;
      off     = k % RD;
      blanked = lz && (slot != 0) && ((v >> (4 * slot)) == 16'h0000);
      litNow  = (off >= BC) && !blanked;
      e.hex   = v[slot*4 +: 4];
      e.an    = litNow ? ~(4'b0001 << slot) : 4'b1111;
      e.dp    = litNow ? ~dpv[slot] : 1'b1;
      e.ack   = ack;
      e.tick  = (k > 0) && (k % (4 * RD) == 0);
      return e;
   endfunction

   function automatic string fmt(exp_t e);
      return $sformatf("an=%b hex=%h dp=%b ack=%b tick=%b", e.an, e.hex, e.dp, e.ack, e.tick);
   endfunction

   function automatic exp_t observed();
      exp_t o;
      o = {an, hexDigit, dp, loadAck, frameTick};
      return o;
   endfunction

   task automatic applyStimulus(input bit doLoad, input logic [15:0] v, input logic [3:0] d);
      load    = doLoad;
      valueIn = v;
      dpIn    = d;
   endtask

   task automatic doReset(input bit lz);
      @(negedge clk);
      reset = 1'b1;
      lzb   = lz;
      applyStimulus(1'b0, 16'h0000, 4'h0);
      sbQueue.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      exp_t want, got;
      @(negedge clk);
      reset = 1'b1;
      lzb   = 1'b0;
      applyStimulus(1'b0, 16'h0000, 4'h0);
      sbQueue.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      want = modelAt(0, 16'h0000, 4'h0, 1'b0, 1'b0);
      got  = observed();
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL reset_hold: got %s want %s", fmt(got), fmt(want));
      end
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         applyStimulus(1'b0, 16'h0000, 4'h0);
         sbQueue.push_back(modelAt(k + 1, 16'h0000, 4'h0, 1'b0, 1'b0));
         @(posedge clk);
         @(negedge clk);
         got = observed();
         checks++;
         if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL reset_run cycle %0d: scoreboard empty", k + 1);
         end else begin
            want = sbQueue.pop_front();
            if (got !== want) begin
               failures++;
               $display("[TB] FAIL reset_run cycle %0d: got %s want %s", k + 1, fmt(got), fmt(want));
            end
         end
      end
   endtask

   task automatic test_load();
      exp_t want, got;
      bit   nw;
      doReset(1'b0);
      for (int k = 0; k < 72; k++) begin
         applyStimulus(k == 5, 16'h12AF, 4'b0100);
         nw = (k + 1) >= 32;
         sbQueue.push_back(modelAt(k + 1, nw ? 16'h12AF : 16'h0000, nw ? 4'b0100 : 4'h0,
                                   1'b0, (k + 1) == 32));
         @(posedge clk);
         @(negedge clk);
         got = observed();
         checks++;
         if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL load cycle %0d: scoreboard empty", k + 1);
         end else begin
            want = sbQueue.pop_front();
            if (got !== want) begin
               failures++;
               $display("[TB] FAIL load cycle %0d: got %s want %s", k + 1, fmt(got), fmt(want));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t want, got;
      doReset(1'b0);
      for (int k = 0; k < 72; k++) begin
         applyStimulus((k == 3) || (k == 20), (k < 10) ? 16'h1111 : 16'h2222, 4'h0);
         sbQueue.push_back(modelAt(k + 1, ((k + 1) >= 32) ? 16'h2222 : 16'h0000, 4'h0,
                                   1'b0, (k + 1) == 32));
         @(posedge clk);
         @(negedge clk);
         got = observed();
         checks++;
         if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL back_to_back cycle %0d: scoreboard empty", k + 1);
         end else begin
            want = sbQueue.pop_front();
            if (got !== want) begin
               failures++;
               $display("[TB] FAIL back_to_back cycle %0d: got %s want %s", k + 1, fmt(got), fmt(want));
            end
         end
      end
   endtask

   task automatic test_wrap_load();
      exp_t want, got;
      doReset(1'b0);
      for (int k = 0; k < 70; k++) begin
         applyStimulus(k == 31, 16'h00A5, 4'h0);
         sbQueue.push_back(modelAt(k + 1, ((k + 1) >= 64) ? 16'h00A5 : 16'h0000, 4'h0,
                                   1'b0, (k + 1) == 64));
         @(posedge clk);
         @(negedge clk);
         got = observed();
         checks++;
         if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL wrap_load cycle %0d: scoreboard empty", k + 1);
         end else begin
            want = sbQueue.pop_front();
            if (got !== want) begin
               failures++;
               $display("[TB] FAIL wrap_load cycle %0d: got %s want %s", k + 1, fmt(got), fmt(want));
            end
         end
      end
   endtask

   task automatic test_lzb();
      exp_t        want, got;
      logic [15:0] v;
      logic [3:0]  d;
      doReset(1'b1);
      for (int k = 0; k < 100; k++) begin
         applyStimulus((k == 5) || (k == 40), (k < 20) ? 16'h0005 : 16'h0105, 4'b1111);
         v = ((k + 1) < 32) ? 16'h0000 : (((k + 1) < 64) ? 16'h0005 : 16'h0105);
         d = ((k + 1) < 32) ? 4'h0 : 4'b1111;
         sbQueue.push_back(modelAt(k + 1, v, d, 1'b1, ((k + 1) == 32) || ((k + 1) == 64)));
         @(posedge clk);
         @(negedge clk);
         got = observed();
         checks++;
         if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL lzb cycle %0d: scoreboard empty", k + 1);
         end else begin
            want = sbQueue.pop_front();
            if (got !== want) begin
               failures++;
               $display("[TB] FAIL lzb cycle %0d: got %s want %s", k + 1, fmt(got), fmt(want));
            end
         end
      end
      lzb = 1'b0;
   endtask

   task automatic test_reset_abort();
      exp_t want, got;
      doReset(1'b0);
      for (int k = 0; k < 14; k++) begin
         applyStimulus(k == 5, 16'h1234, 4'b1010);
         if (k == 13) begin
            reset = 1'b1;
            sbQueue.push_back(modelAt(0, 16'h0000, 4'h0, 1'b0, 1'b0));
         end else begin
            sbQueue.push_back(modelAt(k + 1, 16'h0000, 4'h0, 1'b0, 1'b0));
         end
         @(posedge clk);
         @(negedge clk);
         got = observed();
         checks++;
         if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL abort_pre cycle %0d: scoreboard empty", k + 1);
         end else begin
            want = sbQueue.pop_front();
            if (got !== want) begin
               failures++;
               $display("[TB] FAIL abort_pre cycle %0d: got %s want %s", k + 1, fmt(got), fmt(want));
            end
         end
      end
      reset = 1'b0;
      for (int k = 0; k < 72; k++) begin
         applyStimulus(1'b0, 16'h0000, 4'h0);
         sbQueue.push_back(modelAt(k + 1, 16'h0000, 4'h0, 1'b0, 1'b0));
         @(posedge clk);
         @(negedge clk);
         got = observed();
         checks++;
         if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL abort_post cycle %0d: scoreboard empty", k + 1);
         end else begin
            want = sbQueue.pop_front();
            if (got !== want) begin
               failures++;
               $display("[TB] FAIL abort_post cycle %0d: got %s want %s", k + 1, fmt(got), fmt(want));
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      lzb   = 1'b0;
      applyStimulus(1'b0, 16'h0000, 4'h0);
      $display("[TB] starting seg_scan_controller bench");
      test_reset();
      test_load();
      test_back_to_back();
      test_wrap_load();
      test_lzb();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
